// File: rtl/cla_serial_adder_ctrl.sv
// Multi-cycle WIDTH-bit adder: one 4-bit carry-lookahead slice is reused for
// every nibble, LSB nibble first. The block captures the operands, walks the
// nibble counter, registers the inter-nibble carry and assembles the result.
// Valid/ready handshakes are used on both the operand side and the result side.

// 4-bit carry-lookahead slice. It exports the carry into bit 3 and the carry
// out of bit 3, so that signed overflow can be formed on the last nibble.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       carry_msb_in,
    output logic       carry_out
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Flattened lookahead equations; no carry ripples through the slice.
    assign c[0] = g[0] | (p[0] & cin);
    assign c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s            = p ^ {c[2:0], cin};
    assign carry_msb_in = c[2];
    assign carry_out    = c[3];
endmodule

module cla_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("cla_serial_adder_ctrl: WIDTH must be a multiple of 4 and >= 4");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [CW-1:0]       idx;
    logic                carry_reg;
    logic [NIB-1:0][3:0] a_reg;
    logic [NIB-1:0][3:0] b_reg;
    logic [NIB-1:0][3:0] sum_reg;
    logic                cout_reg;
    logic                ovf_reg;
    logic                out_valid_reg;

    logic [3:0]          nib_a;
    logic [3:0]          nib_b;
    logic [3:0]          nib_s;
    logic                nib_c2;
    logic                nib_c3;
    logic                last_nib;

    assign last_nib = (idx == CW'(NIB - 1));

    // Select the operand nibbles addressed by the nibble counter.
    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIB; i++) begin
            if (idx == CW'(i)) begin
                nib_a = a_reg[i];
                nib_b = b_reg[i];
            end
        end
    end

    cla4 u_cla (
        .a            (nib_a),
        .b            (nib_b),
        .cin          (carry_reg),
        .s            (nib_s),
        .carry_msb_in (nib_c2),
        .carry_out    (nib_c3)
    );

    // Next-state logic: accept in IDLE, walk the nibbles in RUN, hand off in DONE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid) next_state = RUN;
            RUN:     if (last_nib) next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // State register and the registered result-valid flag.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
        end else begin
            state         <= next_state;
            out_valid_reg <= (next_state == DONE);
        end
    end

    // Datapath: operand capture, per-nibble sum write-back, carry chaining.
    // NOTE: the operand and sum registers are reset as well, so a reset leaves no stale result visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx       <= '0;
                        sum_reg   <= '0;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIB; i++) begin
                        if (idx == CW'(i)) sum_reg[i] <= nib_s;
                    end
                    carry_reg <= nib_c3;
                    if (last_nib) begin
                        cout_reg <= nib_c3;
                        ovf_reg  <= nib_c2 ^ nib_c3;
                    end else begin
                        idx <= idx + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign cout      = cout_reg;
    assign ovf       = ovf_reg;
endmodule
